// File: rtl/ttl_74166_ser.sv
// 74LS166-style parallel-load / serial-shift register with optional frame tracking.
// Define TTL_74166_FRAME_EN to add the bit counter and the Busy/Done frame flags.
module ttl_74166_ser #(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             Clk_inhibit,
  input  logic             Shift_load_bar,
  input  logic             Ser,
  input  logic [WIDTH-1:0] D,
  output logic             QH,
  output logic             Busy,
  output logic             Done
);

  logic [WIDTH-1:0] shreg = '0;
  logic             busy;
  logic             done;

  // The data path behaves the same whether or not frame tracking is built in.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      shreg <= '0;
    end else if (!Clk_inhibit) begin
      if (!Shift_load_bar) shreg <= D;
      else                 shreg <= {shreg[WIDTH-2:0], Ser};
    end
  end

`ifdef TTL_74166_FRAME_EN
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t        state = IDLE;
  state_t        state_next;
  logic [CW-1:0] cnt = '0;
  logic [CW-1:0] cnt_next;
  logic          done_q = 1'b0;
  logic          done_next;

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      done_q <= done_next;
    end
  end

  // Done defaults low so it drops on the next edge even while the clock is inhibited;
  // a load always wins over the frame-ending shift.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    if (!Clk_inhibit) begin
      if (!Shift_load_bar) begin
        state_next = FRAME;
        cnt_next   = CNT_LAST;
      end else if (state == FRAME) begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
    end
  end

  assign busy = (state == FRAME);
  assign done = done_q;
`else
  assign busy = 1'b0;
  assign done = 1'b0;
`endif

  assign #(DELAY_RISE, DELAY_FALL) QH   = shreg[WIDTH-1];
  assign #(DELAY_RISE, DELAY_FALL) Busy = busy;
  assign #(DELAY_RISE, DELAY_FALL) Done = done;

endmodule

// File: tb/tb_ttl_74166_ser.sv
// Testbench for ttl_74166_ser: vector table, directed frame corner cases and random
// stimulus checked against a bit-level reference model.
module tb_ttl_74166_ser;

  localparam int W = 8;
`ifdef TTL_74166_FRAME_EN
  localparam bit FRAME_ON = 1'b1;
`else
  localparam bit FRAME_ON = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Clear_bar = 1'b0;
  logic         Clk_inhibit = 1'b0;
  logic         Shift_load_bar = 1'b1;
  logic         Ser = 1'b0;
  logic [W-1:0] D = '0;
  logic         QH, Busy, Done;

  int total  = 0;
  int passed = 0;

  // Reference model: register contents, shift edges left in the frame, pending Done.
  logic [W-1:0] m_reg  = '0;
  int           m_left = 0;
  bit           m_done = 1'b0;

  typedef struct {
    bit           sl;
    bit           ser;
    bit           inh;
    logic [W-1:0] d;
    bit           qh;
    bit           busy;
    bit           done;
  } vec_t;

  vec_t vecs[11];

  always #5 Clk = ~Clk;

  ttl_74166_ser #(.WIDTH(W), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .Clk            (Clk),
    .Clear_bar      (Clear_bar),
    .Clk_inhibit    (Clk_inhibit),
    .Shift_load_bar (Shift_load_bar),
    .Ser            (Ser),
    .D              (D),
    .QH             (QH),
    .Busy           (Busy),
    .Done           (Done)
  );

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_reg  = '0;
    m_left = 0;
    m_done = 1'b0;
  endtask

  task automatic model_edge(input bit sl, input bit ser, input bit inh, input logic [W-1:0] d);
    m_done = 1'b0;
    if (!inh) begin
      if (!sl) begin
        m_reg  = d;
        m_left = W;
      end else begin
        m_reg = {m_reg[W-2:0], ser};
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, " QH"},   QH,   m_reg[W-1]);
    check({tag, " Busy"}, Busy, FRAME_ON && (m_left > 0));
    check({tag, " Done"}, Done, FRAME_ON && m_done);
  endtask

  // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next edge.
  task automatic apply_stimulus(input bit sl, input bit ser, input bit inh, input logic [W-1:0] d);
    Shift_load_bar = sl;
    Ser            = ser;
    Clk_inhibit    = inh;
    D              = d;
    @(posedge Clk);
    if (Clear_bar) model_edge(sl, ser, inh, d);
    #1;
  endtask

  task automatic step(input bit sl, input bit ser, input bit inh, input logic [W-1:0] d, input string tag);
    apply_stimulus(sl, ser, inh, d);
    check_output(tag);
  endtask

  // Pulse Clear_bar low between edges and confirm the outputs drop without a clock.
  task automatic mid_reset(input string tag);
    #3;
    Clear_bar = 1'b0;
    #1;
    model_reset();
    check(tag, QH | Busy | Done, 1'b0);
    check_output(tag);
    #1;
    Clear_bar = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    // Reset held from time zero; a load edge during reset must be ignored.
    #2;
    check_output("reset");
    Shift_load_bar = 1'b0;
    D              = 8'hFF;
    @(posedge Clk);
    #1;
    check("reset ignores edge QH", QH, 1'b0);
    check("reset ignores edge Busy", Busy, 1'b0);
    Clear_bar = 1'b1;

    // Basic frame: load A5, shift zeros through.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].sl, vecs[i].ser, vecs[i].inh, vecs[i].d);
      check($sformatf("vec%0d QH", i),   QH,   vecs[i].qh);
      check($sformatf("vec%0d Busy", i), Busy, FRAME_ON && vecs[i].busy);
      check($sformatf("vec%0d Done", i), Done, FRAME_ON && vecs[i].done);
      check_output($sformatf("vec%0d model", i));
    end

    // Clock inhibit for three cycles after the second shift stretches the frame.
    step(1'b0, 1'b0, 1'b0, 8'hA5, "inh load");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, '0, "inh pre");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, '0, "inh hold");
      check("inh hold QH=1", QH, 1'b1);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, "inh post");
    check("inh no early Done", Done, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, "inh end");
    check("inh late Done", Done, FRAME_ON);
    // Done must drop on the next edge even with the clock inhibited.
    step(1'b1, 1'b0, 1'b1, '0, "inh done clear");
    check("Done clears under inhibit", Done, 1'b0);

    // Reload 3C at the fourth shift restarts the frame with no Done.
    step(1'b0, 1'b0, 1'b0, 8'hA5, "reload first");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, "reload pre");
    step(1'b0, 1'b0, 1'b0, 8'h3C, "reload edge");
    check("reload QH", QH, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, "reload shift");
      check("reload no Done", Done, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, '0, "reload end");
    check("reload Done", Done, FRAME_ON);

    // Load on the frame-ending edge wins: Busy stays, no Done.
    step(1'b0, 1'b0, 1'b0, 8'h81, "prio load");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, '0, "prio shift");
    step(1'b0, 1'b0, 1'b0, 8'h0F, "prio reload");
    check("prio Busy", Busy, FRAME_ON);
    check("prio Done", Done, 1'b0);

    // Asynchronous clear mid-frame aborts it; no Done afterwards.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, '0, "abort shift");
    mid_reset("abort clear");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, "abort after");
      check("abort no Done", Done, 1'b0);
    end

    // Free-running shift of ones after the frame ended.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, "free run");
      check("free run QH", QH, 1'b1);
      check("free run Busy", Busy, 1'b0);
    end

    // Random traffic with occasional asynchronous clears.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(7) != 0), $urandom_range(1), ($urandom_range(4) == 0),
           W'($urandom), "random");
      if ($urandom_range(49) == 0) mid_reset("random clear");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ttl_74166_ser.md
TTL_74166_SER -- requirements
Module: ttl_74166_ser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register length in bits, legal range 2..32.
REQ-002 SHALL have parameter DELAY_RISE, default 0, rise delay in ns applied to QH, Busy and Done.
REQ-003 SHALL have parameter DELAY_FALL, default 0, fall delay in ns applied to QH, Busy and Done.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all synchronous actions occur on its rising edge.
REQ-005 SHALL have port Clear_bar, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port Clk_inhibit, input, 1 bit: when high, blocks every synchronous action except clearing Done.
REQ-007 SHALL have port Shift_load_bar, input, 1 bit: 0 selects parallel load, 1 selects shift.
REQ-008 SHALL have port Ser, input, 1 bit: serial input shifted into bit 0.
REQ-009 SHALL have port D, input, WIDTH bits: parallel load data.
REQ-010 SHALL have port QH, output, 1 bit: serial output, equal to register bit WIDTH-1.
REQ-011 SHALL have port Busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port Done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-013 Enabled edge = rising Clk edge with Clear_bar=1 and Clk_inhibit=0; only enabled edges SHALL alter the register, Busy or the bit counter.
REQ-014 On an enabled edge with Shift_load_bar=0, the register SHALL load D; Busy SHALL become 1; the counter SHALL become WIDTH-1; Done SHALL be 0.
REQ-015 On an enabled edge with Shift_load_bar=1, the register SHALL become {reg[WIDTH-2:0], Ser}.
REQ-016 On a shift edge with Busy=1 and counter>0, the counter SHALL decrement by 1.
REQ-017 On a shift edge with Busy=1 and counter=0, Busy SHALL clear to 0 and Done SHALL pulse to 1.
REQ-018 On a shift edge with Busy=0, the counter and Busy SHALL be unchanged and Done SHALL be 0 (free-running shift).
REQ-019 Frame: D[WIDTH-1] SHALL appear on QH after the load edge, then D[WIDTH-2]..D[0] after each subsequent shift edge; Busy SHALL stay high for exactly WIDTH enabled edges after the load.
REQ-020 Done SHALL clear on the next rising Clk edge regardless of Clk_inhibit; it SHALL never be high longer than one Clk cycle.
REQ-021 A load during Busy=1 SHALL restart the frame with no Done pulse; a load on the edge that would end the frame SHALL take priority, leaving Done=0 and Busy=1.
REQ-022 QH, Busy and Done SHALL be driven through #(DELAY_RISE, DELAY_FALL); internal state SHALL carry no delay.
REQ-023 The register and state SHALL power up at 0 (simulation initial value).

Reset
REQ-024 Clear_bar=0 SHALL immediately, without a clock edge, force the register, counter, Busy and Done to 0, and hence QH to 0.
REQ-025 While Clear_bar=0, Clk edges SHALL be ignored; the first enabled edge after release SHALL act normally.
REQ-026 A reset mid-frame SHALL abort the frame with no Done pulse.

Configuration
REQ-027 Macro TTL_74166_FRAME_EN SHALL be the only configuration switch.
REQ-028 With TTL_74166_FRAME_EN defined, the counter, Busy and Done SHALL be implemented per REQ-014..REQ-021.
REQ-029 Without TTL_74166_FRAME_EN, the counter SHALL be omitted and Busy and Done SHALL be tied to 0; register/QH behaviour SHALL be identical (pure 74LS166 model).

Verification
REQ-030 Test: WIDTH=8; load D=8'hA5, then shift with Ser=0 -> QH reads 1,0,1,0,0,1,0,1 on successive cycles; Busy is high for 8 cycles; Done is high for 1 cycle at the 8th shift edge.
REQ-031 Test: load D=8'hA5; hold Clk_inhibit=1 for 3 cycles after the 2nd shift -> QH holds 1 for those cycles; Busy is held; Done is delayed by 3 cycles.
REQ-032 Test: load D=8'hA5; reload D=8'h3C at the 4th shift -> no Done; QH reads 0,0,1,1,1,1,0,0; Done follows 8 edges after the reload.
REQ-033 Test: pull Clear_bar low mid-frame between edges -> QH, Busy and Done are 0 at once; no Done after release.
REQ-034 Test: after a frame ends, shift 8 times with Ser=1 -> QH=1; Busy stays 0; Done stays 0.
REQ-035 Test: macro undefined; rerun REQ-030 -> QH sequence is identical; Busy=Done=0 throughout.
